// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        DRAIN
    } fetch_state_e;

    localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/pc_next_mux.sv
// Priority select of the next PC: boot > exception > redirect > sequential advance > hold.
module pc_next_mux
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
    input  logic        sel_boot,
    input  logic        sel_exc,
    input  logic        sel_redir,
    input  logic        sel_adv,
    input  logic [31:0] pc_out,
    input  logic [31:0] redir_target,
    output logic [31:0] pc_new
);

    always_comb begin
        pc_new = pc_out;
        if (sel_boot) begin
            pc_new = RESET_PC;
        end else if (sel_exc) begin
            pc_new = EXC_VECTOR;
        end else if (sel_redir) begin
            pc_new = redir_target;
        end else if (sel_adv) begin
            // Modulo 2^32; the carry out is intentionally dropped.
            pc_new = pc_out + PC_INC;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch sequencer: drives pc_reg, runs the imem request/ack handshake and feeds decode.
// Define MISALIGN_TRAP_EN to trap redirects whose target is not word aligned.
module pc_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0100
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_out,
    output logic [31:0] pc_new,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        redir_valid,
    input  logic [31:0] redir_target,
    input  logic        exc_valid,
    output logic        misalign_err
);

    fetch_state_e state_q, state_d;
    logic [31:0]  inst_out_q, inst_pc_q;
    logic         misalign_err_q, misalign_err_d;
    logic [31:0]  tgt;
    logic         misalign;
    logic         active, take_exc, take_redir, flush;
    logic         adv, load;

`ifdef MISALIGN_TRAP_EN
    assign misalign = redir_valid & (redir_target[1:0] != 2'b00);
    assign tgt      = redir_target;
`else
    logic unused_tgt_lsb;
    assign unused_tgt_lsb = ^redir_target[1:0];
    assign misalign       = 1'b0;
    assign tgt            = {redir_target[31:2], 2'b00};
`endif

    // Redirects and exceptions are ignored while booting.
    assign active         = (state_q != BOOT);
    assign take_exc       = active & (exc_valid | misalign);
    assign take_redir     = active & redir_valid & ~take_exc;
    assign flush          = take_exc | take_redir;
    assign misalign_err_d = active & misalign & ~exc_valid;

    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        adv      = 1'b0;
        load     = 1'b0;
        unique case (state_q)
            BOOT: state_d = FETCH;
            FETCH: begin
                imem_req = 1'b1;
                if (flush) begin
                    // A same-cycle ack retires the stale request; otherwise wait it out.
                    state_d = imem_ack ? FETCH : DRAIN;
                end else if (imem_ack) begin
                    load    = 1'b1;
                    adv     = 1'b1;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (flush || inst_ready) begin
                    state_d = FETCH;
                end
            end
            // The outstanding ack still ends the drain even if another redirect arrives.
            DRAIN: begin
                if (imem_ack) begin
                    state_d = FETCH;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= BOOT;
            inst_out_q     <= 32'h0;
            inst_pc_q      <= 32'h0;
            misalign_err_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            misalign_err_q <= misalign_err_d;
            if (load) begin
                inst_out_q <= imem_rdata;
                inst_pc_q  <= pc_out;
            end
        end
    end

    pc_next_mux #(
        .RESET_PC  (RESET_PC),
        .EXC_VECTOR(EXC_VECTOR)
    ) u_pc_next_mux (
        .sel_boot    (state_q == BOOT),
        .sel_exc     (take_exc),
        .sel_redir   (take_redir),
        .sel_adv     (adv),
        .pc_out      (pc_out),
        .redir_target(tgt),
        .pc_new      (pc_new)
    );

    assign imem_addr    = pc_out;
    assign inst_valid   = (state_q == HOLD) & ~redir_valid & ~exc_valid;
    assign inst_out     = inst_out_q;
    assign inst_pc      = inst_pc_q;
    assign misalign_err = misalign_err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Scoreboard bench for pc_fetch_ctrl with a pc_reg model and a latency-configurable imem responder.
module tb_pc_fetch_ctrl;

    localparam logic [31:0] KEY = 32'h1357_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_out;
    logic [31:0] pc_new;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc_valid;
    logic        misalign_err;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   mem_lat  = 1;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_out      (pc_out),
        .pc_new      (pc_new),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready),
        .inst_out    (inst_out),
        .inst_pc     (inst_pc),
        .redir_valid (redir_valid),
        .redir_target(redir_target),
        .exc_valid   (exc_valid),
        .misalign_err(misalign_err)
    );

    // pc_reg: loads pc_new every edge, resets to the boot address.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc_out <= 32'h0;
        else        pc_out <= pc_new;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] word);
        exp_t e;
        e.pc   = pc;
        e.word = word;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        inst_ready = 1'b1;
        while (exp_q.size() != 0 && n < 60) begin
            tick();
            n++;
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        inst_ready = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!inst_valid && n < 40) begin
            tick();
            n++;
        end
        check(name, 32'(inst_valid), 32'd1);
    endtask

    // Instruction memory: acks mem_lat cycles after seeing a request; data = addr ^ KEY.
    initial begin
        logic        busy;
        int          cnt;
        logic [31:0] addr;
        busy       = 1'b0;
        cnt        = 0;
        addr       = 32'h0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            imem_ack = 1'b0;
            if (busy) begin
                cnt--;
                if (cnt == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = addr ^ KEY;
                    busy       = 1'b0;
                end
            end else if (imem_req) begin
                busy = 1'b1;
                cnt  = mem_lat;
                addr = imem_addr;
            end
        end
    end

    // Monitor: every decode transfer must match the head of the scoreboard.
    initial begin
        forever begin : mon
            exp_t e;
            @(negedge clk);
            if (rst_n && inst_valid && inst_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_xfer: got pc %h word %h required no transfer",
                             inst_pc, inst_out);
                end else begin
                    e = exp_q.pop_front();
                    check("xfer_pc", inst_pc, e.pc);
                    check("xfer_word", inst_out, e.word);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] mis_pc;
        int          n;
        rst_n        = 1'b0;
        inst_ready   = 1'b0;
        redir_valid  = 1'b0;
        redir_target = 32'h0;
        exc_valid    = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst_out", inst_out, 32'h0);
        check("rst_inst_pc", inst_pc, 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'd0);
        check("rst_pc_new", pc_new, 32'h0);
        rst_n = 1'b1;

        // Sequential fetch 0, 4, 8 with back-to-back acceptance.
        push(32'h0, 32'h1357_0000);
        push(32'h4, 32'h1357_0004);
        push(32'h8, 32'h1357_0008);
        drain("t1");
        check("t1_pc_out", pc_out, 32'hC);

        // Decode stalls: the held word stays valid and no new fetch starts.
        mem_lat = 2;
        wait_valid("t2_valid");
        check("t2_inst_pc", inst_pc, 32'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_valid", 32'(inst_valid), 32'd1);
            check("t2_hold_req", 32'(imem_req), 32'd0);
            check("t2_hold_pc_out", pc_out, 32'h10);
        end
        push(32'hC, 32'h1357_000C);
        drain("t2");

        // Redirect during FETCH; the in-flight word for 0x10 must be dropped.
        redir_valid  = 1'b1;
        redir_target = 32'h40;
        tick();
        redir_valid = 1'b0;
        check("t3_drain_req", 32'(imem_req), 32'd0);
        check("t3_pc_out", pc_out, 32'h40);
        push(32'h40, 32'h1357_0040);
        drain("t3");

        // Exception and redirect together in HOLD; the exception wins and 0x44 is flushed.
        wait_valid("t4_valid");
        exc_valid    = 1'b1;
        redir_valid  = 1'b1;
        redir_target = 32'h80;
        inst_ready   = 1'b1;
        #1;
        check("t4_cancel_valid", 32'(inst_valid), 32'd0);
        check("t4_pc_new", pc_new, 32'h100);
        tick();
        exc_valid   = 1'b0;
        redir_valid = 1'b0;
        check("t4_pc_out", pc_out, 32'h100);
        push(32'h100, 32'h1357_0100);
        drain("t4");

        // Sequential advance wraps at the top of the address space.
        wait_valid("t5_valid");
        redir_valid  = 1'b1;
        redir_target = 32'hFFFF_FFFC;
        tick();
        redir_valid = 1'b0;
        check("t5_pc_out", pc_out, 32'hFFFF_FFFC);
        n = 0;
        while (!imem_ack && n < 20) begin
            tick();
            n++;
        end
        check("t5_ack_seen", 32'(imem_ack), 32'd1);
        check("t5_imem_addr", imem_addr, 32'hFFFF_FFFC);
        check("t5_pc_new_wrap", pc_new, 32'h0);
        push(32'hFFFF_FFFC, 32'hECA8_FFFC);
        drain("t5");
        check("t5_pc_out_wrap", pc_out, 32'h0);

        // Misaligned redirect: trapped to the vector, or fetched word-aligned.
        wait_valid("t6_valid");
        redir_valid  = 1'b1;
        redir_target = 32'h42;
`ifdef MISALIGN_TRAP_EN
        mis_pc = 32'h100;
`else
        mis_pc = 32'h40;
`endif
        #1;
        check("t6_pc_new", pc_new, mis_pc);
        tick();
        redir_valid = 1'b0;
        check("t6_pc_out", pc_out, mis_pc);
`ifdef MISALIGN_TRAP_EN
        check("t6_misalign_pulse", 32'(misalign_err), 32'd1);
`else
        check("t6_misalign_tied", 32'(misalign_err), 32'd0);
`endif
        tick();
        check("t6_misalign_end", 32'(misalign_err), 32'd0);
        push(mis_pc, mis_pc ^ KEY);
        drain("t6");

        // Reset while a fetch is outstanding; the late ack lands in BOOT and is ignored.
        check("t7_req_before", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t7_req", 32'(imem_req), 32'd0);
        check("t7_valid", 32'(inst_valid), 32'd0);
        check("t7_inst_out", inst_out, 32'h0);
        check("t7_inst_pc", inst_pc, 32'h0);
        check("t7_misalign", 32'(misalign_err), 32'd0);
        check("t7_pc_new", pc_new, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("t7_boot_pc_new", pc_new, 32'h0);
        check("t7_boot_req", 32'(imem_req), 32'd0);
        push(32'h0, 32'h1357_0000);
        drain("t7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
